// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit_if : control, instruction-memory and IR-side bus signals   |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
interface fetch_unit_if;
    logic       stall;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic [7:0] ir_new;
    logic       sf1_out;
    logic       flush;
    logic [7:0] pc;
    logic [7:0] pc_plus1;

    modport master (
        input  stall, branch_taken, branch_target, imem_data,
        output imem_addr, ir_new, sf1_out, flush, pc, pc_plus1
    );

    modport slave (
        output stall, branch_taken, branch_target, imem_data,
        input  imem_addr, ir_new, sf1_out, flush, pc, pc_plus1
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : 8-bit PC sequencer with reset vector, 1/2-byte fetch    |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module fetch_unit #(
    parameter logic [3:0] TWO_BYTE_OP = 4'hC
) (
    input  wire logic        clk,
    input  wire logic        rst,
    fetch_unit_if.master     bus
);

    typedef enum logic [1:0] {
        VEC = 2'd0,
        OP  = 2'd1,
        IMM = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_pc;
    logic [7:0] w_pc_next;
    logic [7:0] w_pc_inc;

    assign w_pc_inc = r_pc + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc    <= 8'h00;
            r_state <= VEC;
        end else begin
            r_pc    <= w_pc_next;
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_pc_next    = r_pc;
        w_state_next = r_state;
        bus.imem_addr = r_pc;
        bus.ir_new    = bus.imem_data;
        bus.sf1_out   = 1'b0;
        bus.flush     = 1'b0;
        case (r_state)
            VEC: begin
                bus.imem_addr = 8'h00;
                bus.ir_new    = 8'h00;
                w_pc_next     = bus.imem_data;
                w_state_next  = OP;
            end
            OP, IMM: begin
                bus.sf1_out = (r_state == IMM);
                bus.flush   = bus.branch_taken;
                // Redirect wins over stall and discards any pending immediate.
                if (bus.branch_taken) begin
                    w_pc_next    = bus.branch_target;
                    w_state_next = OP;
                end else if (!bus.stall) begin
                    w_pc_next = w_pc_inc;
                    if (r_state == OP && bus.imem_data[7:4] == TWO_BYTE_OP)
                        w_state_next = IMM;
                    else
                        w_state_next = OP;
                end
            end
            default: begin
                w_pc_next    = 8'h00;
                w_state_next = VEC;
            end
        endcase
    end

    assign bus.pc       = r_pc;
    assign bus.pc_plus1 = w_pc_inc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_unit : directed self-checking bench for fetch_unit          |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module tb_fetch_unit;
    logic       clk;
    logic       rst;
    logic [7:0] mem [256];
    int         errors;
    int         checks;

    fetch_unit_if bus ();

    fetch_unit #(.TWO_BYTE_OP(4'hC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    assign bus.imem_data = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h10;
        mem[8'h10] = 8'hC3; mem[8'h11] = 8'h5A; mem[8'h12] = 8'h21;
        mem[8'h13] = 8'hC7; mem[8'h14] = 8'h99;
        mem[8'h40] = 8'hC1;
        mem[8'hFE] = 8'h05; mem[8'hFF] = 8'hC0;
        mem[8'h30] = 8'hC2; mem[8'h31] = 8'hAB;

        rst = 1'b0;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 8'h00;
        tick();
        tick();

        // Reset state
        chk("rst_pc",       bus.pc,        8'h00);
        chk("rst_addr",     bus.imem_addr, 8'h00);
        chk("rst_ir",       bus.ir_new,    8'h00);
        chk("rst_sf1",      {7'd0, bus.sf1_out}, 8'h00);
        chk("rst_pc_plus1", bus.pc_plus1,  8'h01);

        // Vector cycle ignores stall and branch
        rst = 1'b1;
        bus.stall = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_target = 8'h55;
        #1;
        chk("vec_flush", {7'd0, bus.flush}, 8'h00);
        chk("vec_addr",  bus.imem_addr, 8'h00);
        chk("vec_ir",    bus.ir_new,    8'h00);
        tick();
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        #1;
        chk("vec_pc",   bus.pc,        8'h10);
        chk("op_addr",  bus.imem_addr, 8'h10);
        chk("op_ir",    bus.ir_new,    8'hC3);
        chk("op_sf1",   {7'd0, bus.sf1_out}, 8'h00);
        chk("op_pcp1",  bus.pc_plus1,  8'h11);

        // Immediate byte, then stall in IMM for two cycles
        tick();
        chk("imm_pc",  bus.pc,     8'h11);
        chk("imm_ir",  bus.ir_new, 8'h5A);
        chk("imm_sf1", {7'd0, bus.sf1_out}, 8'h01);
        bus.stall = 1'b1;
        #1;
        chk("stall_flush", {7'd0, bus.flush}, 8'h00);
        tick();
        chk("stall1_pc",  bus.pc,     8'h11);
        chk("stall1_ir",  bus.ir_new, 8'h5A);
        chk("stall1_sf1", {7'd0, bus.sf1_out}, 8'h01);
        tick();
        bus.stall = 1'b0;
        chk("stall2_pc",  bus.pc,     8'h11);
        chk("stall2_sf1", {7'd0, bus.sf1_out}, 8'h01);
        tick();
        chk("post_stall_pc",  bus.pc,     8'h12);
        chk("post_stall_ir",  bus.ir_new, 8'h21);
        chk("post_stall_sf1", {7'd0, bus.sf1_out}, 8'h00);

        // One-byte op at 12, then two-byte op at 13
        tick();
        chk("op13_pc",  bus.pc,  8'h13);
        chk("op13_sf1", {7'd0, bus.sf1_out}, 8'h00);
        tick();
        chk("imm14_pc",  bus.pc,  8'h14);
        chk("imm14_sf1", {7'd0, bus.sf1_out}, 8'h01);

        // Branch in IMM with stall held: branch wins
        bus.stall = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_target = 8'h40;
        #1;
        chk("br_imm_flush", {7'd0, bus.flush}, 8'h01);
        tick();
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        #1;
        chk("br_pc",    bus.pc,     8'h40);
        chk("br_sf1",   {7'd0, bus.sf1_out}, 8'h00);
        chk("br_ir",    bus.ir_new, 8'hC1);
        chk("br_flush", {7'd0, bus.flush}, 8'h00);

        // Branch in OP discards the would-be immediate
        bus.branch_taken = 1'b1;
        bus.branch_target = 8'hFE;
        #1;
        chk("br_op_flush", {7'd0, bus.flush}, 8'h01);
        tick();
        bus.branch_taken = 1'b0;
        #1;
        chk("fe_pc",  bus.pc, 8'hFE);
        chk("fe_sf1", {7'd0, bus.sf1_out}, 8'h00);

        // Wrap: two-byte opcode at FF, immediate from 00
        tick();
        mem[8'h00] = 8'h77;
        #1;
        chk("ff_pc",    bus.pc,       8'hFF);
        chk("ff_pcp1",  bus.pc_plus1, 8'h00);
        chk("ff_ir",    bus.ir_new,   8'hC0);
        tick();
        chk("wrap_pc",   bus.pc,     8'h00);
        chk("wrap_ir",   bus.ir_new, 8'h77);
        chk("wrap_sf1",  {7'd0, bus.sf1_out}, 8'h01);
        chk("wrap_pcp1", bus.pc_plus1, 8'h01);
        tick();
        chk("wrap_next_pc",  bus.pc, 8'h01);
        chk("wrap_next_sf1", {7'd0, bus.sf1_out}, 8'h00);

        // Mid-operation reset while in IMM at 31
        bus.branch_taken = 1'b1;
        bus.branch_target = 8'h30;
        tick();
        bus.branch_taken = 1'b0;
        tick();
        chk("pre_rst_pc",  bus.pc, 8'h31);
        chk("pre_rst_sf1", {7'd0, bus.sf1_out}, 8'h01);
        rst = 1'b0;
        bus.stall = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_target = 8'h99;
        #1;
        chk("rst_sync_pc",  bus.pc, 8'h31);
        chk("rst_sync_sf1", {7'd0, bus.sf1_out}, 8'h01);
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_pc",    bus.pc,        8'h00);
        chk("mid_rst_sf1",   {7'd0, bus.sf1_out}, 8'h00);
        chk("mid_rst_addr",  bus.imem_addr, 8'h00);
        chk("mid_rst_ir",    bus.ir_new,    8'h00);
        chk("mid_rst_flush", {7'd0, bus.flush}, 8'h00);
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        tick();
        chk("reload_pc", bus.pc, 8'h77);
        chk("reload_sf1", {7'd0, bus.sf1_out}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
